uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among num_req_p byte-stream requesters. Round-robin grant at
//  packet granularity: a granted requester holds the line until it sends a byte flagged last.
//  Sequences uart_tx: pulses tx_v_o with one byte, waits for tx_done_i, then takes the next byte.
//  Sits between on-board agents (console, debug, loopback) and the uart_tx driving tx_o.
// PARAMETERS
//  num_req_p    4  number of requesters, 2..8
//  data_bits_p  8  byte width; must match uart_tx data_bits_p
// PORTS
//  clk_i          in   1                       system clock
//  reset_n_i      in   1                       asynchronous, active-low reset
//  req_v_i        in   num_req_p               per-requester byte valid
//  req_data_i     in   num_req_p*data_bits_p   per-requester byte; requester r uses slice r
//  req_last_i     in   num_req_p               byte is last of packet; grant released after it
//  req_ready_o    out  num_req_p               byte accepted on the cycle (v & ready)
//  tx_v_o         out  1                       one-cycle start pulse to uart_tx
//  tx_data_o      out  data_bits_p             byte to uart_tx; held stable until tx_done_i
//  tx_done_i      in   1                       uart_tx finished a frame (stop bits sent)
//  grant_id_o     out  $clog2(num_req_p)       current owner; meaningful only when busy_o
//  busy_o         out  1                       a packet is in progress
// BEHAVIOUR
//  Reset (async assert, sync deassert by the integrator): state IDLE, tx_v_o=0, tx_data_o=0,
//   req_ready_o=0, busy_o=0, grant_id_o=0, rr pointer=0 (requester 0 highest priority).
//  States: IDLE -> (TAG) -> LOAD -> WAIT -> LOAD | IDLE.
//  IDLE: if any req_v_i, grant first set bit at or after rr pointer (wrap-around); grant_id_o
//   latched, busy_o=1 next cycle. Grant decision takes 1 cycle; no byte accepted in IDLE.
//  LOAD: req_ready_o[grant]=1 for exactly the cycle req_v_i[grant]=1; on that cycle latch byte
//   and last flag, go WAIT; tx_v_o=1 on the next cycle (one cycle, WAIT entry). Other ready=0.
//   If owner drops req_v_i, stay in LOAD (grant held, no timeout).
//  WAIT: tx_data_o held; on tx_done_i: if latched last=1 -> IDLE, busy_o=0, rr pointer =
//   grant+1 mod num_req_p; else -> LOAD. tx_done_i outside WAIT is ignored.
//  Throughput: ready-to-next-ready >= frame time + 2 cycles; bus of uart_tx never overlapped.
//  Simultaneous requests: fairness is per packet; a requester waits at most num_req_p-1 packets.
//  req_v_i may rise/fall freely for non-owners; only owner's v/data/last are sampled.
//  Reset mid-frame: arbiter returns to IDLE immediately; partial packet is dropped, the
//   requester sees no ready; uart_tx must be reset by the same source.
// CONFIGURATION
//  UART_ARB_TAG_EN defined: after grant, state TAG sends one header byte
//   {zero-extended grant_id} through the same tx_v_o/tx_done_i sequence before first LOAD;
//   req_ready_o stays 0 during TAG. Requires data_bits_p >= $clog2(num_req_p).
//  Undefined: TAG state absent; IDLE goes directly to LOAD; no header byte on the wire.
// STRUCTURE
//  Package uart_arb_pkg: state enum (e_idle, e_tag, e_load, e_wait), id width function
//   localparam, tag byte builder. Sub-module uart_rr_pick: combinational round-robin picker
//   (req vector + pointer -> one-hot + index + any); arbiter keeps state, pointer, byte regs.
// TESTING
//  1 single req0 packet 0x41,0x42(last); tx_done 20 cyc after each tx_v -> two tx_v pulses,
//    data 0x41 then 0x42, busy_o falls cycle after 2nd done, pointer=1.
//  2 req0..3 all valid, 1-byte packets -> grant order 0,1,2,3,0; no tx_v during WAIT.
//  3 req2 holds 3-byte packet while req1 requests -> bytes of req2 contiguous, req1 next.
//  4 owner drops valid mid-packet 50 cycles -> stays LOAD, no tx_v, resumes on valid.
//  5 reset_n_i low during WAIT -> all outputs 0 asynchronously; after release, IDLE, ptr 0.
//  6 UART_ARB_TAG_EN, num_req_p=4, req3 sends 0x55(last) -> wire bytes 0x03 then 0x55.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and helpers for the uart_tx arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_tag  = 2'd1,
        e_load = 2'd2,
        e_wait = 2'd3
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Header byte announcing the owner: the grant id, zero-extended.
    function automatic logic [31:0] tag_byte(input logic [31:0] id);
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and uart_tx handshake bundle around the arbiter.
//               slave = arbiter side, master = requesters + uart_tx side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = 8
) ();
    localparam int c_ID_W = id_width(num_req_p);

    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p*data_bits_p-1:0] req_data_i;
    logic [num_req_p-1:0]             req_last_i;
    logic [num_req_p-1:0]             req_ready_o;
    logic                             tx_v_o;
    logic [data_bits_p-1:0]           tx_data_o;
    logic                             tx_done_i;
    logic [c_ID_W-1:0]                grant_id_o;
    logic                             busy_o;

    modport slave (
        input  req_v_i, req_data_i, req_last_i, tx_done_i,
        output req_ready_o, tx_v_o, tx_data_o, grant_id_o, busy_o
    );

    modport master (
        output req_v_i, req_data_i, req_last_i, tx_done_i,
        input  req_ready_o, tx_v_o, tx_data_o, grant_id_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker: first set request at or
//               after the pointer, with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        int   v_j;
        logic v_found;
        v_j      = 0;
        v_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_j = (int'(i_ptr) + i) % NUM_REQ;
            if (!v_found && i_req[v_j]) begin
                v_found     = 1'b1;
                o_idx       = ID_W'(v_j);
                o_onehot[v_j] = 1'b1;
            end
        end
        o_any = v_found;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin sharing of one uart_tx among
//               num_req_p byte streams. Optional owner header byte when
//               UART_ARB_TAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = 8
) (
    input  wire logic        clk_i,
    input  wire logic        reset_n_i,
    uart_tx_arbiter_if.slave bus
);

    localparam int                c_ID_W    = id_width(num_req_p);
    localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(num_req_p - 1);

    arb_state_t             r_state,    w_state_nxt;
    logic [c_ID_W-1:0]      r_ptr,      w_ptr_nxt;
    logic [c_ID_W-1:0]      r_grant,    w_grant_nxt;
    logic [num_req_p-1:0]   r_grant_oh, w_grant_oh_nxt;
    logic [data_bits_p-1:0] r_data,     w_data_nxt;
    logic                   r_last,     w_last_nxt;
    logic                   r_tx_v,     w_tx_v_nxt;
    logic                   r_busy,     w_busy_nxt;

    logic [num_req_p-1:0]   w_ready;
    logic [num_req_p-1:0]   w_pick_oh;
    logic [c_ID_W-1:0]      w_pick_idx;
    logic                   w_pick_any;
    logic [data_bits_p-1:0] w_req_byte;
    logic                   w_req_last;

    uart_rr_pick #(
        .NUM_REQ (num_req_p),
        .ID_W    (c_ID_W)
    ) u_pick (
        .i_req    (bus.req_v_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Only the owner's byte and last flag are ever looked at.
    assign w_req_byte = bus.req_data_i[int'(r_grant)*data_bits_p +: data_bits_p];
    assign w_req_last = bus.req_last_i[r_grant];

`ifdef UART_ARB_TAG_EN
    logic [data_bits_p-1:0] w_tag;
    assign w_tag = data_bits_p'(tag_byte(32'(r_grant)));
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_oh_nxt = r_grant_oh;
        w_data_nxt     = r_data;
        w_last_nxt     = r_last;
        w_tx_v_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_ready        = '0;
        case (r_state)
            e_idle: begin
                if (w_pick_any) begin
                    w_grant_nxt    = w_pick_idx;
                    w_grant_oh_nxt = w_pick_oh;
                    w_busy_nxt     = 1'b1;
`ifdef UART_ARB_TAG_EN
                    w_state_nxt    = e_tag;
`else
                    w_state_nxt    = e_load;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            e_tag: begin
                w_data_nxt  = w_tag;
                w_last_nxt  = 1'b0;
                w_tx_v_nxt  = 1'b1;
                w_state_nxt = e_wait;
            end
`endif
            e_load: begin
                w_ready = r_grant_oh & bus.req_v_i;
                if (|w_ready) begin
                    w_data_nxt  = w_req_byte;
                    w_last_nxt  = w_req_last;
                    w_tx_v_nxt  = 1'b1;
                    w_state_nxt = e_wait;
                end
            end
            e_wait: begin
                if (bus.tx_done_i) begin
                    if (r_last) begin
                        w_state_nxt = e_idle;
                        w_busy_nxt  = 1'b0;
                        w_ptr_nxt   = (r_grant == c_LAST_ID) ? '0 : r_grant + 1'b1;
                    end else begin
                        w_state_nxt = e_load;
                    end
                end
            end
            default: w_state_nxt = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_idle;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_tx_v     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_oh <= w_grant_oh_nxt;
            r_data     <= w_data_nxt;
            r_last     <= w_last_nxt;
            r_tx_v     <= w_tx_v_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.tx_v_o      = r_tx_v;
    assign bus.tx_data_o   = r_data;
    assign bus.grant_id_o  = r_grant;
    assign bus.busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a uart_tx model
//               and a packet-level round-robin reference (UART_ARB_TAG_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N  = 4;
    localparam int DB = 8;
`ifdef UART_ARB_TAG_EN
    localparam bit c_TAG = 1'b1;
`else
    localparam bit c_TAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.num_req_p(N), .data_bits_p(DB)) bus ();

    uart_tx_arbiter #(.num_req_p(N), .data_bits_p(DB)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    typedef struct {
        logic [N-1:0] mask;
        int           n;
        int           ord [N];
    } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] q_byte [N][$];
    bit         q_last [N][$];
    int         start_dly [N];
    int         hold [N];
    bit         midpkt [N];
    int         gap_cfg = 0;
    int         m_ptr = 0;
    logic [7:0] exp_byte [$];
    int         exp_own [$];
    int         txv_cyc [$];
    bit         u_busy = 1'b0;
    int         u_cnt = 0;
    logic [7:0] u_data = '0;
    bit         done_now = 1'b0;
    bit         done_last = 1'b0;
    bit         prev_busy = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            q_byte[r].push_back((base < 0) ? 8'($urandom) : 8'(base + i));
            q_last[r].push_back(i == len - 1);
        end
    endtask

    // Expected wire content for a given packet grant order.
    task automatic expect_order(input int ord[$]);
        logic [7:0] cb [N][$];
        bit         cl [N][$];
        bit         l;
        for (int r = 0; r < N; r++) begin
            cb[r] = q_byte[r];
            cl[r] = q_last[r];
        end
        foreach (ord[k]) begin
            if (c_TAG) begin
                exp_byte.push_back(8'(ord[k]));
                exp_own.push_back(ord[k]);
            end
            l = 1'b0;
            while (!l && cb[ord[k]].size() > 0) begin
                exp_byte.push_back(cb[ord[k]].pop_front());
                exp_own.push_back(ord[k]);
                l = cl[ord[k]].pop_front();
            end
            m_ptr = (ord[k] + 1) % N;
        end
    endtask

    // Packet-level round robin over everything queued, starting at m_ptr.
    task automatic model_order(output int ord[$]);
        int  npk [N];
        int  p;
        bit  found;
        ord = {};
        for (int r = 0; r < N; r++) begin
            npk[r] = 0;
            foreach (q_last[r][i]) npk[r] += int'(q_last[r][i]);
        end
        p = m_ptr;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && npk[(p + k) % N] > 0) begin
                    found = 1'b1;
                    ord.push_back((p + k) % N);
                    npk[(p + k) % N]--;
                end
            end
            if (found) p = (ord[ord.size()-1] + 1) % N;
        end
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < N; r++) if (q_byte[r].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle per iteration: sample registered outputs, model uart_tx,
    // drive requesters, then observe ready for the coming edge.
    task automatic run(input int dly, input int stop_after, input int budget, input string nm);
        int   cyc = 0;
        int   seen = 0;
        logic v;
        txv_cyc = {};
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            done_last = done_now;
            done_now = 1'b0;
            bus.tx_done_i = 1'b0;
            if (prev_busy && !bus.busy_o)
                check(done_last, "busy_fall_after_done", int'(done_last), 1);
            if (bus.tx_v_o) begin
                check(!u_busy, "tx_v_overlap", int'(u_busy), 0);
                if (exp_byte.size() == 0) begin
                    check(1'b0, "extra_byte", int'(bus.tx_data_o), -1);
                end else begin
                    check(bus.tx_data_o == exp_byte[0], "wire_byte", int'(bus.tx_data_o), int'(exp_byte[0]));
                    check(int'(bus.grant_id_o) == exp_own[0], "wire_owner", int'(bus.grant_id_o), exp_own[0]);
                    void'(exp_byte.pop_front());
                    void'(exp_own.pop_front());
                end
                u_busy = 1'b1;
                u_data = bus.tx_data_o;
                u_cnt  = (dly > 0) ? dly : int'($urandom_range(2, 10));
                seen++;
                txv_cyc.push_back(cyc);
            end else if (u_busy) begin
                check(bus.tx_data_o == u_data, "tx_data_hold", int'(bus.tx_data_o), int'(u_data));
                u_cnt--;
                if (u_cnt <= 0) begin
                    bus.tx_done_i = 1'b1;
                    done_now = 1'b1;
                    u_busy = 1'b0;
                end
            end
            for (int r = 0; r < N; r++) begin
                v = 1'b0;
                if (start_dly[r] > 0) start_dly[r]--;
                else if (q_byte[r].size() > 0) begin
                    if (midpkt[r] && hold[r] > 0) hold[r]--;
                    else v = 1'b1;
                end
                bus.req_v_i[r] = v;
                bus.req_data_i[r*DB +: DB] = (q_byte[r].size() > 0) ? q_byte[r][0] : 8'h00;
                bus.req_last_i[r] = (q_last[r].size() > 0) ? q_last[r][0] : 1'b0;
            end
            #1;
            check($countones(bus.req_ready_o) <= 1, "ready_onehot", int'(bus.req_ready_o), 0);
            for (int r = 0; r < N; r++) begin
                if (bus.req_ready_o[r]) begin
                    check(bus.req_v_i[r], "ready_without_valid", r, -1);
                    if (bus.req_v_i[r]) begin
                        void'(q_byte[r].pop_front());
                        midpkt[r] = !q_last[r].pop_front();
                        hold[r] = (gap_cfg >= 0) ? gap_cfg : int'($urandom_range(0, 3));
                    end
                end
            end
            prev_busy = bus.busy_o;
            if (stop_after > 0 && seen >= stop_after) break;
            if (stop_after == 0 && all_empty() && !u_busy && !bus.busy_o && !done_now && exp_byte.size() == 0) break;
            if (cyc >= budget) begin
                check(1'b0, {nm, "_timeout"}, cyc, budget);
                break;
            end
        end
        if (stop_after == 0)
            check(exp_byte.size() == 0, {nm, "_missing_bytes"}, exp_byte.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vec [6];
        int   oq [$];
        int   np;

        vec[0] = '{4'b1111, 4, '{0, 1, 2, 3}};
        vec[1] = '{4'b0001, 1, '{0, 0, 0, 0}};
        vec[2] = '{4'b0101, 2, '{2, 0, 0, 0}};
        vec[3] = '{4'b0011, 2, '{1, 0, 0, 0}};
        vec[4] = '{4'b1010, 2, '{1, 3, 0, 0}};
        vec[5] = '{4'b1001, 2, '{0, 3, 0, 0}};

        bus.req_v_i = '0;
        bus.req_data_i = '0;
        bus.req_last_i = '0;
        bus.tx_done_i = 1'b0;
        for (int r = 0; r < N; r++) begin
            start_dly[r] = 0;
            hold[r] = 0;
            midpkt[r] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(bus.tx_v_o == 1'b0, "reset_tx_v", int'(bus.tx_v_o), 0);
        check(bus.tx_data_o == '0, "reset_tx_data", int'(bus.tx_data_o), 0);
        check(bus.req_ready_o == '0, "reset_ready", int'(bus.req_ready_o), 0);
        check(bus.busy_o == 1'b0, "reset_busy", int'(bus.busy_o), 0);
        check(bus.grant_id_o == '0, "reset_grant", int'(bus.grant_id_o), 0);
        reset_n = 1'b1;

        // Arbitration vectors: one-byte packets, pointer carried between rows.
        gap_cfg = 0;
        for (int e = 0; e < 6; e++) begin
            for (int r = 0; r < N; r++)
                if (vec[e].mask[r]) add_pkt(r, 1, 16 * e + r);
            oq = {};
            for (int k = 0; k < vec[e].n; k++) oq.push_back(vec[e].ord[k]);
            expect_order(oq);
            run(4, 0, 400, "vec");
        end

        // Two-byte packet from requester 0 with 20-cycle frames.
        add_pkt(0, 2, 8'h41);
        oq = {0};
        expect_order(oq);
        run(20, 0, 300, "req0_pkt");
        check(txv_cyc.size() == (c_TAG ? 3 : 2), "req0_txv_count", txv_cyc.size(), c_TAG ? 3 : 2);

        // Pointer now at 1: requester 1 ahead of requester 0.
        add_pkt(0, 1, 8'h60);
        add_pkt(1, 1, 8'h61);
        oq = {1, 0};
        expect_order(oq);
        run(3, 0, 200, "ptr_after_pkt");

        // Requester 2 owns a 3-byte packet while requester 1 arrives late.
        add_pkt(2, 3, 8'h70);
        add_pkt(1, 2, 8'h80);
        start_dly[1] = 4;
        oq = {2, 1};
        expect_order(oq);
        run(5, 0, 300, "hold_line");

        // Reset while a frame is in flight.
        add_pkt(2, 3, 8'hA0);
        oq = {2};
        expect_order(oq);
        run(8, 1, 200, "rst_pre");
        #2;
        reset_n = 1'b0;
        #1;
        check(bus.tx_v_o == 1'b0, "async_rst_tx_v", int'(bus.tx_v_o), 0);
        check(bus.tx_data_o == '0, "async_rst_tx_data", int'(bus.tx_data_o), 0);
        check(bus.busy_o == 1'b0, "async_rst_busy", int'(bus.busy_o), 0);
        check(bus.grant_id_o == '0, "async_rst_grant", int'(bus.grant_id_o), 0);
        check(bus.req_ready_o == '0, "async_rst_ready", int'(bus.req_ready_o), 0);
        for (int r = 0; r < N; r++) begin
            q_byte[r].delete();
            q_last[r].delete();
            midpkt[r] = 1'b0;
            hold[r] = 0;
        end
        exp_byte.delete();
        exp_own.delete();
        u_busy = 1'b0;
        done_now = 1'b0;
        prev_busy = 1'b0;
        m_ptr = 0;
        bus.req_v_i = '0;
        bus.tx_done_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        add_pkt(0, 1, 8'hB0);
        add_pkt(3, 1, 8'hB3);
        oq = {0, 3};
        expect_order(oq);
        run(3, 0, 200, "ptr_after_reset");

        // Owner withholds valid for 50 cycles mid-packet.
        gap_cfg = 50;
        add_pkt(1, 3, 8'hC0);
        oq = {1};
        expect_order(oq);
        run(5, 0, 600, "owner_gap");
        np = c_TAG ? 2 : 1;
        if (txv_cyc.size() > np)
            check(txv_cyc[np] - txv_cyc[np-1] >= 50, "owner_gap_len", txv_cyc[np] - txv_cyc[np-1], 50);
        else
            check(1'b0, "owner_gap_txv_count", txv_cyc.size(), np + 1);

        // Single byte from requester 3 (header 0x03 precedes it when tagged).
        gap_cfg = 0;
        add_pkt(3, 1, 8'h55);
        oq = {3};
        expect_order(oq);
        run(6, 0, 200, "req3_byte");

        // Randomized packets, random frame times and random owner pauses.
        gap_cfg = -1;
        for (int round = 0; round < 3; round++) begin
            for (int r = 0; r < N; r++) begin
                np = int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) add_pkt(r, int'($urandom_range(1, 4)), -1);
            end
            model_order(oq);
            expect_order(oq);
            run(-1, 0, 5000, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
